activation_control: RTL



---
 rtl/tpu_pkg.sv | 33 +++
 rtl/delay_line.sv | 30 +++
 rtl/activation_control.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU types: activation function encoding, activation instruction bundle,
// activation sequencer state encoding and default widths/latencies.
package tpu_pkg;

  localparam int unsigned ACT_MATRIX_WIDTH       = 14;
  localparam int unsigned ACT_ACC_ADDR_WIDTH     = 9;
  localparam int unsigned ACT_BUFFER_ADDR_WIDTH  = 24;
  localparam int unsigned ACT_LENGTH_WIDTH       = 32;
  localparam int unsigned ACT_READ_LATENCY       = 2;
  localparam int unsigned ACT_ACTIVATION_LATENCY = 3;

  // NO_ACTIVATION must stay at zero: cleared pipeline stages read as "no function"
  typedef enum logic [1:0] {
    NO_ACTIVATION = 2'd0,
    RELU          = 2'd1,
    SIGMOID       = 2'd2
  } activation_type;

  typedef struct packed {
    logic [ACT_ACC_ADDR_WIDTH-1:0]    acc_addr;
    logic [ACT_BUFFER_ADDR_WIDTH-1:0] buf_addr;
    logic [ACT_LENGTH_WIDTH-1:0]      length;
    activation_type                   func;
    logic                             is_signed;
  } activation_instr_type;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } act_ctrl_state_type;

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with synchronous clear and shared stall enable.
module delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else if (enable) begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/activation_control.sv
// Activation-stage sequencer: walks accumulator rows into the activation unit and
// issues the matching unified-buffer writes once each row emerges.
module activation_control
  import tpu_pkg::*;
#(
  parameter int unsigned MATRIX_WIDTH       = ACT_MATRIX_WIDTH,
  parameter int unsigned ACC_ADDR_WIDTH     = ACT_ACC_ADDR_WIDTH,
  parameter int unsigned BUFFER_ADDR_WIDTH  = ACT_BUFFER_ADDR_WIDTH,
  parameter int unsigned LENGTH_WIDTH       = ACT_LENGTH_WIDTH,
  parameter int unsigned READ_LATENCY       = ACT_READ_LATENCY,
  parameter int unsigned ACTIVATION_LATENCY = ACT_ACTIVATION_LATENCY
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         instr_valid,
  input  logic [ACC_ADDR_WIDTH-1:0]    instr_acc_addr,
  input  logic [BUFFER_ADDR_WIDTH-1:0] instr_buf_addr,
  input  logic [LENGTH_WIDTH-1:0]      instr_length,
  input  activation_type               instr_function,
  input  logic                         instr_signed,
  output logic                         busy,
  output logic                         done,
  output logic                         acc_rd_en,
  output logic [ACC_ADDR_WIDTH-1:0]    acc_rd_addr,
  output activation_type               act_function,
  output logic                         act_signed,
  output logic                         buf_wr_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] buf_wr_addr
);

  // Valid line stops one stage short; the last stage is buf_wr_en_q so the
  // write address can be loaded in the same edge as the strobe.
  localparam int unsigned VALID_DEPTH = READ_LATENCY + ACTIVATION_LATENCY - 1;
  localparam int unsigned FN_W        = $bits(activation_type) + 1;

  if (READ_LATENCY < 1 || ACTIVATION_LATENCY < 1 || MATRIX_WIDTH < 1 ||
      ACC_ADDR_WIDTH != ACT_ACC_ADDR_WIDTH || BUFFER_ADDR_WIDTH != ACT_BUFFER_ADDR_WIDTH ||
      LENGTH_WIDTH != ACT_LENGTH_WIDTH) begin : g_bad_params
    $error("activation_control: unsupported parameter set");
  end

  act_ctrl_state_type               state_q;
  activation_instr_type             cur_q;
  logic [LENGTH_WIDTH-1:0]          wr_left_q;
  logic                             busy_q;
  logic                             done_q;
  logic                             acc_rd_en_q;
  logic [ACC_ADDR_WIDTH-1:0]        acc_rd_addr_q;
  logic                             buf_wr_en_q;
  logic [BUFFER_ADDR_WIDTH-1:0]     buf_wr_addr_q;

  logic                             wr_pre;
  logic [FN_W-1:0]                  fn_d;
  logic [FN_W-1:0]                  fn_tap;

  // Function/sign ride alongside each read so back-to-back instructions never mix
  assign fn_d = acc_rd_en_q ? {cur_q.func, cur_q.is_signed} : '0;

  delay_line #(
    .WIDTH (1),
    .DEPTH (VALID_DEPTH)
  ) u_valid_dly (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .d      (acc_rd_en_q),
    .q      (wr_pre)
  );

  delay_line #(
    .WIDTH (FN_W),
    .DEPTH (READ_LATENCY)
  ) u_fn_dly (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .d      (fn_d),
    .q      (fn_tap)
  );

  // cur_q is the working copy of the instruction: acc_addr/buf_addr hold the next
  // address to issue and length the reads still owed after the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cur_q         <= '0;
      wr_left_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      acc_rd_en_q   <= 1'b0;
      acc_rd_addr_q <= '0;
      buf_wr_en_q   <= 1'b0;
      buf_wr_addr_q <= '0;
    end else if (enable) begin
      done_q      <= 1'b0;
      buf_wr_en_q <= wr_pre;
      if (wr_pre) begin
        buf_wr_addr_q  <= BUFFER_ADDR_WIDTH'(cur_q.buf_addr);
        cur_q.buf_addr <= cur_q.buf_addr + ACT_BUFFER_ADDR_WIDTH'(1);
        wr_left_q      <= wr_left_q - LENGTH_WIDTH'(1);
        if (wr_left_q == LENGTH_WIDTH'(1)) begin
          done_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            cur_q <= '{acc_addr:  ACT_ACC_ADDR_WIDTH'(instr_acc_addr + ACC_ADDR_WIDTH'(1)),
                       buf_addr:  ACT_BUFFER_ADDR_WIDTH'(instr_buf_addr),
                       length:    ACT_LENGTH_WIDTH'(instr_length - LENGTH_WIDTH'(1)),
                       func:      instr_function,
                       is_signed: instr_signed};
            wr_left_q <= instr_length;
            if (instr_length != '0) begin
              state_q       <= ST_READ;
              busy_q        <= 1'b1;
              acc_rd_en_q   <= 1'b1;
              acc_rd_addr_q <= instr_acc_addr;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (cur_q.length == '0) begin
            acc_rd_en_q <= 1'b0;
            state_q     <= ST_DRAIN;
          end else begin
            acc_rd_addr_q  <= ACC_ADDR_WIDTH'(cur_q.acc_addr);
            cur_q.acc_addr <= cur_q.acc_addr + ACT_ACC_ADDR_WIDTH'(1);
            cur_q.length   <= cur_q.length - ACT_LENGTH_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          // done_q marks the cycle of the last write; leave one cycle later
          if (done_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign acc_rd_en    = acc_rd_en_q;
  assign acc_rd_addr  = acc_rd_addr_q;
  assign act_function = activation_type'(fn_tap[FN_W-1:1]);
  assign act_signed   = fn_tap[0];
  assign buf_wr_en    = buf_wr_en_q;
  assign buf_wr_addr  = buf_wr_addr_q;

endmodule
